// File: rtl/rb_arbiter_pkg.sv
// Shared widths, lock limit and requester IDs for the register-bank arbiter.
package rb_arbiter_pkg;

    localparam int RB_AW      = 5;
    localparam int RB_DW      = 32;
    localparam int RB_MAXLOCK = 4;

    typedef enum logic {
        RID_A = 1'b0,
        RID_B = 1'b1
    } rid_e;

    function automatic rid_e rid_other(input rid_e r);
        return (r == RID_A) ? RID_B : RID_A;
    endfunction

endpackage

// File: rtl/rb_arbiter_pick.sv
// Two-way round-robin grant with a bounded lock; owns the pointer and lock count.
module rr_pick2
    import rb_arbiter_pkg::*;
#(
    parameter int MAXLOCK = RB_MAXLOCK
) (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic lock_a,
    input  logic lock_b,
    output logic gnt_a,
    output logic gnt_b
);

    localparam int CW = $clog2(MAXLOCK + 1);

    rid_e          ptr;
    rid_e          win;
    logic [CW-1:0] cnt;
    logic          lim;
    logic          pick_b;
    logic          win_lock;

    // The count only grows while the pointer sits on the locking owner.
    assign lim = (cnt == CW'(MAXLOCK));

    always_comb begin
        pick_b = 1'b0;
        unique case (1'b1)
            (req_a && req_b):  pick_b = (ptr == RID_B) ^ lim;
            (req_b && !req_a): pick_b = 1'b1;
            default:           pick_b = 1'b0;
        endcase
    end

    assign gnt_a    = reset & req_a & ~pick_b;
    assign gnt_b    = reset & req_b & pick_b;
    assign win      = pick_b ? RID_B : RID_A;
    assign win_lock = pick_b ? lock_b : lock_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= RID_A;
            cnt <= '0;
        end else if (gnt_a || gnt_b) begin
            if (win_lock) begin
                ptr <= win;
                if (ptr != win)
                    cnt <= CW'(1);
                else if (!lim)
                    cnt <= cnt + 1'b1;
            end else begin
                ptr <= rid_other(win);
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rb_arbiter.sv
// Arbitrates two requesters onto one register bank: command stage, then read capture.
module rb_arbiter
    import rb_arbiter_pkg::*;
#(
    parameter int AW      = RB_AW,
    parameter int DW      = RB_DW,
    parameter int MAXLOCK = RB_MAXLOCK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic          lock_a,
    input  logic          lock_b,
    input  logic [AW-1:0] sr1_a,
    input  logic [AW-1:0] sr2_a,
    input  logic [AW-1:0] dr_a,
    input  logic [AW-1:0] sr1_b,
    input  logic [AW-1:0] sr2_b,
    input  logic [AW-1:0] dr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [AW-1:0] rb_sr1,
    output logic [AW-1:0] rb_sr2,
    output logic [AW-1:0] rb_dr,
    output logic [DW-1:0] rb_wdata,
    output logic          rb_write,
    input  logic [DW-1:0] rb_regd1,
    input  logic [DW-1:0] rb_regd2
);

    logic c_vld;
    logic c_we;
    rid_e c_own;

    rr_pick2 #(
        .MAXLOCK(MAXLOCK)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .req_a (req_a),
        .req_b (req_b),
        .lock_a(lock_a),
        .lock_b(lock_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_vld    <= 1'b0;
            c_we     <= 1'b0;
            c_own    <= RID_A;
            rb_sr1   <= '0;
            rb_sr2   <= '0;
            rb_dr    <= '0;
            rb_wdata <= '0;
        end else begin
            c_vld <= gnt_a | gnt_b;
            if (gnt_a || gnt_b) begin
                c_own    <= gnt_b ? RID_B : RID_A;
                c_we     <= gnt_b ? we_b : we_a;
                rb_sr1   <= gnt_b ? sr1_b : sr1_a;
                rb_sr2   <= gnt_b ? sr2_b : sr2_a;
                rb_dr    <= gnt_b ? dr_b : dr_a;
                rb_wdata <= gnt_b ? wdata_b : wdata_a;
            end
        end
    end

    assign rb_write = c_vld & c_we;

    // Bank read data is combinational, so it is valid while the command is staged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata1   <= '0;
            rdata2   <= '0;
        end else begin
            rvalid_a <= c_vld & ~c_we & (c_own == RID_A);
            rvalid_b <= c_vld & ~c_we & (c_own == RID_B);
            if (c_vld && !c_we) begin
                rdata1 <= rb_regd1;
                rdata2 <= rb_regd2;
            end
        end
    end

endmodule

// File: doc/rb_arbiter.md
RB_ARBITER -- requirements
Module: rb_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AW, 5, register address width (32 registers).
- DW, 32, register data width.
- MAXLOCK, 4, max consecutive grants to one locking requester while the other waits.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous active-low reset.
- req_a / req_b, in, 1, requester A/B command valid.
- we_a / we_b, in, 1, command is a write (1) or a two-operand read (0).
- lock_a / lock_b, in, 1, request to keep the grant for the next command.
- sr1_a, sr2_a, dr_a / sr1_b, sr2_b, dr_b, in, AW, source and destination register addresses.
- wdata_a / wdata_b, in, DW, write data.
- gnt_a / gnt_b, out, 1, command accepted this cycle (combinational from req and state).
- rvalid_a / rvalid_b, out, 1, read response valid, one-cycle pulse.
- rdata1, rdata2, out, DW, read response operands, shared by both requesters.
- rb_sr1, rb_sr2, rb_dr, out, AW, register bank address drive.
- rb_wdata, out, DW, register bank write data.
- rb_write, out, 1, register bank write enable.
- rb_regd1, rb_regd2, in, DW, register bank combinational read data.

Function
REQ-003 Handshake: a command is accepted at edge E0 when req_x and gnt_x are both high; at most one of gnt_a and gnt_b is high in any cycle.
REQ-004 gnt_x depends on req_a, req_b, the priority pointer and the lock state only; it never depends on gnt_x itself.
REQ-005 Arbitration: round-robin. The pointer names the favoured requester and, after each accepted command, moves to the other requester unless REQ-006 holds.
REQ-006 Lock: if the accepted command has lock_x=1, the pointer stays on x; the lock counter increments per consecutive locked grant and clears on a grant without lock or a switch of owner.
REQ-007 Lock limit: when the counter reaches MAXLOCK and the other requester has req high, the other requester is granted next; when the other is idle, grants to x continue and the counter saturates.
REQ-008 Single requester: a lone requester is granted every cycle, independent of the pointer.
REQ-009 Command stage: the accepted command is registered at E0 and drives rb_sr1, rb_sr2, rb_dr and rb_wdata during the cycle after E0; rb_write equals we of that command and is 0 in cycles with no registered command.
REQ-010 Writes commit in the bank at E1 = E0 + 1 clock; a write produces no rvalid.
REQ-011 Reads: rb_regd1 and rb_regd2 are captured at E1; rdata1, rdata2 and rvalid_x (owner only) are high for exactly the cycle after E1, giving a 2-cycle latency from acceptance.
REQ-012 rdata1 and rdata2 hold their last value when rvalid is low.
REQ-013 Back-to-back: one command is accepted per cycle, with no bubbles. A read accepted at E0+1 after a write to the same address at E0 returns the newly written data.
REQ-014 Simultaneous req_a and req_b with both lock inputs low alternate strictly, A B A B, starting from the pointer value.

Reset
REQ-015 While reset=0: gnt_a, gnt_b, rvalid_a, rvalid_b and rb_write are 0; rb_sr1, rb_sr2, rb_dr, rb_wdata, rdata1 and rdata2 are 0; the pointer is A; the lock counter is 0; the command stage is empty.
REQ-016 A reset asserted mid-operation discards in-flight commands and never produces a late rb_write or rvalid. The first acceptance is possible in the first cycle after release.

Structure
REQ-017 A shared package holds AW, DW, MAXLOCK and the requester-ID encoding (A=0, B=1).
REQ-018 One sub-module, rr_pick2: the 2-way round-robin/lock grant logic, holding the pointer and lock counter.

Verification
REQ-019 Reset, then A writes wdata=10*i to dr=i for i=0..31 -> rb_write pulses, and a later read of sr1=4, sr2=5 returns rvalid_a two cycles after gnt with rdata1=40, rdata2=50.
REQ-020 req_a and req_b both held high, both reads, no lock, 6 cycles -> grant sequence A,B,A,B,A,B; each rvalid reaches the correct owner 2 cycles after its grant.
REQ-021 lock_a=1 with req_a and req_b held high -> A granted exactly 4 consecutive times, then B; with req_b=0 -> A granted for more than 4 consecutive cycles.
REQ-022 A writes 0xDEADBEEF to reg 7, then A reads sr1=7 in the next cycle -> rdata1=0xDEADBEEF.
REQ-023 reset driven low in the cycle after a write grant -> no rb_write at the following edge, all outputs 0, and the target register keeps its old value.
